// File: rtl/group_update_sequencer.sv
// group_update_sequencer: steps group_EN through 0..NUM_GROUPS-1 with a programmable dwell per group.
// Repeats for a programmed number of sweeps. Optional macro GROUP_GAP_EN adds one idle cycle after every group.
`default_nettype none

module group_update_sequencer #(
   parameter int NUM_GROUPS = 3,
   parameter int DWELL_W    = 8,
   parameter int SWEEP_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [DWELL_W-1:0] dwell_cycles,
   input  logic [SWEEP_W-1:0] num_sweeps,
   output logic [0:2]         group_EN,
   output logic               update_en,
   output logic               busy,
   output logic               sweep_done,
   output logic [SWEEP_W-1:0] sweep_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
`ifdef GROUP_GAP_EN
   localparam logic [1:0] S_GAP  = 2'd2;
`endif
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [2:0] LAST_GRP = 3'(NUM_GROUPS - 1);

   logic [1:0]         state_q, state_d;
   logic [2:0]         group_q, group_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [DWELL_W-1:0] dwell_len_q, dwell_len_d;
   logic [SWEEP_W-1:0] target_q, target_d;
   logic [SWEEP_W-1:0] count_q, count_d;
   logic               stop_pend_q, stop_pend_d;
   logic               stop_seen;
   logic [SWEEP_W-1:0] count_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         group_q     <= '0;
         dwell_cnt_q <= '0;
         dwell_len_q <= '0;
         target_q    <= '0;
         count_q     <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         group_q     <= group_d;
         dwell_cnt_q <= dwell_cnt_d;
         dwell_len_q <= dwell_len_d;
         target_q    <= target_d;
         count_q     <= count_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   // A stop seen in the deciding cycle itself counts toward ending the run.
   assign stop_seen = stop_pend_q | stop;
   assign count_inc = count_q + SWEEP_W'(1);

   always_comb begin
      state_d     = state_q;
      group_d     = group_q;
      dwell_cnt_d = dwell_cnt_q;
      dwell_len_d = dwell_len_q;
      target_d    = target_q;
      count_d     = count_q;
      stop_pend_d = stop_pend_q;
      case (state_q)
         S_IDLE: begin
            stop_pend_d = 1'b0;
            if (start) begin
               state_d     = S_RUN;
               group_d     = '0;
               dwell_len_d = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
               dwell_cnt_d = ((dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles) - DWELL_W'(1);
               target_d    = num_sweeps;
               count_d     = '0;
            end
         end
         S_RUN: begin
            stop_pend_d = stop_seen;
            if (dwell_cnt_q == '0) begin
               dwell_cnt_d = dwell_len_q - DWELL_W'(1);
               if (group_q != LAST_GRP) begin
                  group_d = group_q + 3'd1;
`ifdef GROUP_GAP_EN
                  state_d = S_GAP;
`endif
               end else begin
                  group_d = '0;
                  count_d = count_inc;
`ifdef GROUP_GAP_EN
                  state_d = S_GAP;
`else
                  if (((target_q != '0) && (count_inc == target_q)) || stop_seen)
                     state_d = S_DONE;
`endif
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            end
         end
`ifdef GROUP_GAP_EN
         S_GAP: begin
            stop_pend_d = stop_seen;
            // Group 0 in GAP means the sweep just completed; the count is already updated.
            if ((group_q == '0) &&
                (((target_q != '0) && (count_q == target_q)) || stop_seen))
               state_d = S_DONE;
            else
               state_d = S_RUN;
         end
`endif
         S_DONE: begin
            state_d     = S_IDLE;
            group_d     = '0;
            stop_pend_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            group_d = '0;
         end
      endcase
   end

   always_comb begin
      update_en   = (state_q == S_RUN);
      busy        = (state_q != S_IDLE);
      sweep_done  = (state_q == S_DONE);
      group_EN    = group_q;
      sweep_count = count_q;
   end

endmodule

`default_nettype wire

// File: doc/group_update_sequencer.md
# group_update_sequencer

Sequential driver for the p-bit grouped update order decoder. Steps a group index through groups 0 to NUM_GROUPS-1, holding each group for a programmable dwell and repeating for a programmed number of sweeps. Produces `group_EN`, which feeds the group-to-Pbit_EN decoder directly, plus a qualifying `update_en` strobe that gates the p-bit enables. Sits between the run-control/host registers and the decoder.

## Interface
Parameters:
- NUM_GROUPS, 3, number of update groups; legal 2..8; group codes 0..NUM_GROUPS-1
- DWELL_W, 8, width of dwell-length input
- SWEEP_W, 16, width of sweep target and sweep counter

Ports:
- clk  in  1  single clock domain; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; ignored while busy=1
- stop  in  1  request graceful stop at end of current sweep; ignored while busy=0
- dwell_cycles  in  DWELL_W  enabled cycles per group; sampled on accepted start; 0 treated as 1
- num_sweeps  in  SWEEP_W  sweeps per run; sampled on accepted start; 0 = free-run until stop
- group_EN  out  [0:2]  current group code, drives decoder; always in 0..NUM_GROUPS-1
- update_en  out  1  high when the current group's p-bits may update
- busy  out  1  run in progress (RUN, GAP or DONE state)
- sweep_done  out  1  one-cycle pulse at end of run
- sweep_count  out  SWEEP_W  completed sweeps in current/last run

## Operation
- States: IDLE, RUN, GAP, DONE.
- IDLE: update_en=0, busy=0, group_EN holds 3'b000. Accepted start -> RUN; loads group 0, dwell counter, sweep target; clears sweep_count.
- RUN: update_en=1 for max(dwell_cycles,1) cycles on current group. On last dwell cycle:
  - group < NUM_GROUPS-1: advance group (via GAP if GROUP_GAP_EN), reload dwell.
  - group = NUM_GROUPS-1: sweep_count+1 (wraps at 2^SWEEP_W only in free-run); then DONE if (num_sweeps≠0 and new count = num_sweeps) or stop pending, else group 0 and continue.
- GAP (GROUP_GAP_EN only): one cycle, update_en=0, group_EN already shows next group.
- DONE: one cycle; sweep_done=1, busy=1, update_en=0; group_EN returns to 0; -> IDLE.
- stop sets a sticky pending flag, cleared on entry to IDLE; never truncates a sweep.
- start and stop in same IDLE cycle: start accepted, stop ignored.
- group_EN never presents a code ≥ NUM_GROUPS (decoder has no default arm).
- Reset at any time: immediately IDLE, all outputs to reset values, pending stop cleared.

## Timing
- Reset values: group_EN=0, update_en=0, busy=0, sweep_done=0, sweep_count=0.
- start sampled at edge N -> busy=1, update_en=1, group_EN=0 from cycle N+1.
- Group duration D=max(dwell_cycles,1) cycles; group switch is registered, no glitch.
- Sweep length: NUM_GROUPS·D cycles without gap; NUM_GROUPS·(D+1) with gap (gap also after last group).
- sweep_done pulses the cycle after the final sweep's last RUN (or GAP) cycle; busy falls the cycle after sweep_done.
- sweep_count updates on the same edge as the final-group to group-0/DONE transition.

## Configuration
- GROUP_GAP_EN defined: one update_en=0 GAP cycle inserted after every group, so neighbouring groups never update on adjacent cycles.
- GROUP_GAP_EN undefined: GAP state removed; groups update back-to-back, update_en stays high continuously through a run.

## Test plan
- Reset mid-run: rst_n low during RUN group 1 -> next cycle all outputs 0, state IDLE; subsequent start behaves normally.
- No gap, dwell_cycles=2, num_sweeps=2, start -> group_EN sequence 0,0,1,1,2,2 ×2 with update_en=1 for 12 cycles, sweep_count=2, sweep_done one pulse, busy low next cycle.
- GROUP_GAP_EN, dwell_cycles=1, num_sweeps=1 -> update_en pattern 1,0,1,0,1,0 on groups 0,1,2; sweep_done at cycle 7.
- dwell_cycles=0 -> identical to dwell_cycles=1; start while busy -> ignored, sweep_count unaffected.
- num_sweeps=0 free-run, stop asserted mid group 1 of sweep 3 -> run completes sweep 3, sweep_count=3, sweep_done pulses, group_EN never outside 0..2.
